// File: rtl/nand_gate_pkg.sv
// Shared definitions for the nand_gate block: width limit, the reference
// NAND function and the 1-bit gate result type.
package nand_gate_pkg;

  localparam int MAX_WIDTH = 64;

  typedef logic nand_bit_t;
  typedef logic [MAX_WIDTH-1:0] nand_vec_t;

  // Full-width reference NAND; callers extend operands and pick their bits.
  function automatic nand_vec_t nand_vec(input nand_vec_t a, input nand_vec_t b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/nand_bit_cell.sv
// Single-bit 2-input NAND cell, the leaf gate of the nand_gate block.
module nand_bit_cell
  import nand_gate_pkg::*;
(
  input  nand_bit_t a_i,
  input  nand_bit_t b_i,
  output nand_bit_t y_o
);

  assign y_o = ~(a_i & b_i);

endmodule

// File: rtl/nand_gate.sv
// Bitwise WIDTH-bit NAND with a combinational result and a registered,
// valid-qualified copy. Optional AND-reduce NAND output: NAND_GATE_REDUCE_EN.
module nand_gate
  import nand_gate_pkg::*;
#(
  parameter int   WIDTH     = 1,
  parameter logic RESET_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
`ifdef NAND_GATE_REDUCE_EN
  output logic             red,
  output logic             red_q,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             valid_d, valid_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    nand_bit_cell u_cell (
      .a_i (a[i]),
      .b_i (b[i]),
      .y_o (out[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (in_valid) begin
      data_d  = out;
      valid_d = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so all registers sample together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= {WIDTH{RESET_OUT}};
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out_q     = data_q;
  assign out_valid = valid_q;

`ifdef NAND_GATE_REDUCE_EN
  nand_vec_t a_ext, b_ext, nand_ext;
  logic      red_d, red_q_r;

  // Unused upper lanes are padded with ones so their NAND is 0 and they
  // drop out of the OR below: ~&(a & b) == |~(a & b).
  always_comb begin
    a_ext            = '1;
    b_ext            = '1;
    a_ext[WIDTH-1:0] = a;
    b_ext[WIDTH-1:0] = b;
  end

  assign nand_ext = nand_vec(a_ext, b_ext);
  assign red      = |nand_ext;
  assign red_d    = in_valid ? red : red_q_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) red_q_r <= 1'b1;
    else        red_q_r <= red_d;
  end

  assign red_q = red_q_r;
`endif

endmodule

// File: tb/tb_nand_gate.sv
// Self-checking bench for nand_gate: WIDTH=1, 8 and 4 instances, directed
// cases plus randomized traffic against a queue-based model.
module tb_nand_gate;
  import nand_gate_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       a1, b1, out1, outq1, ov1, iv1;
  logic [7:0] a8, b8, out8, outq8;
  logic       iv8, ov8;
  logic [3:0] a4, b4, out4, outq4;
  logic       iv4, ov4;
`ifdef NAND_GATE_REDUCE_EN
  logic       red1, redq1, red8, redq8, red4, redq4;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nand_gate #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1),
    .out(out1), .out_q(outq1),
`ifdef NAND_GATE_REDUCE_EN
    .red(red1), .red_q(redq1),
`endif
    .out_valid(ov1)
  );

  nand_gate #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8),
    .out(out8), .out_q(outq8),
`ifdef NAND_GATE_REDUCE_EN
    .red(red8), .red_q(redq8),
`endif
    .out_valid(ov8)
  );

  nand_gate #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(iv4),
    .out(out4), .out_q(outq4),
`ifdef NAND_GATE_REDUCE_EN
    .red(red4), .red_q(redq4),
`endif
    .out_valid(ov4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] n8(input logic [7:0] x, input logic [7:0] y);
    nand_vec_t full;
    full = nand_vec(64'(x), 64'(y));
    return full[7:0];
  endfunction

  function automatic logic [3:0] n4(input logic [3:0] x, input logic [3:0] y);
    nand_vec_t full;
    full = nand_vec(64'(x), 64'(y));
    return full[3:0];
  endfunction

  // Model for the 8-bit registered path: results captured since the last
  // reset, and whether the previous edge carried a capture.
  logic [7:0] cap_hist[$];
  logic       exp_v = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cap_hist.delete();
        exp_v = 1'b0;
      end else begin
        exp_v = iv8;
        if (iv8) cap_hist.push_back(n8(a8, b8));
      end
    end
  end

  function automatic logic [7:0] exp_q8();
    return (cap_hist.size() == 0) ? 8'hFF : cap_hist[$];
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      check("w8_out", 64'(out8), 64'(n8(a8, b8)));
      check("w8_out_q", 64'(outq8), 64'(exp_q8()));
      check("w8_out_valid", 64'(ov8), 64'(exp_v));
      check("w4_out", 64'(out4), 64'(n4(a4, b4)));
`ifdef NAND_GATE_REDUCE_EN
      check("w4_red", 64'(red4), 64'(~&(a4 & b4)));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [7:0] sa[4];
  logic [7:0] sb[4];

  initial begin
    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; iv8 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; iv4 = 1'b0;

    // 1-bit truth table, clock-independent, while held in reset.
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = 2'(i);
      #1;
      check("w1_truth", 64'(out1), 64'((i == 3) ? 1'b0 : 1'b1));
      #49;
    end

    check("w8_reset_out_q", 64'(outq8), 64'h00FF);
    check("w8_reset_valid", 64'(ov8), 64'h0);
`ifdef NAND_GATE_REDUCE_EN
    check("w4_reset_red_q", 64'(redq4), 64'h1);
`endif

    a8 = 8'hF0; b8 = 8'hCC; #1; check("w8_comb_f0_cc", 64'(out8), 64'h3F);
    a8 = 8'hFF; b8 = 8'hFF; #1; check("w8_comb_ff_ff", 64'(out8), 64'h00);
    a8 = 8'h00; b8 = 8'hFF; #1; check("w8_comb_00_ff", 64'(out8), 64'hFF);

    @(posedge clk);
    #2 rst_n = 1'b1;

    // Single capture, then hold.
    step();
    a8 = 8'hAA; b8 = 8'h0F; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
    check("reg_capture_q", 64'(outq8), 64'hF5);
    check("reg_capture_v", 64'(ov8), 64'h1);
    a8 = 8'h12; b8 = 8'h34;
    step();
    check("reg_hold_q", 64'(outq8), 64'hF5);
    check("reg_hold_v", 64'(ov8), 64'h0);

    // Asynchronous reset between edges; out keeps tracking a/b.
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_q", 64'(outq8), 64'hFF);
    check("async_rst_v", 64'(ov8), 64'h0);
    a8 = 8'h0F; b8 = 8'h3C; #1;
    check("rst_out_tracks", 64'(out8), 64'hF3);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Four back-to-back captures.
    sa = '{8'h11, 8'hA5, 8'hFF, 8'h3C};
    sb = '{8'hF0, 8'h5A, 8'h81, 8'h3C};
    step();
    for (int k = 0; k < 4; k++) begin
      a8 = sa[k]; b8 = sb[k]; iv8 = 1'b1;
      step();
      check("stream_q", 64'(outq8), 64'(n8(sa[k], sb[k])));
      check("stream_v", 64'(ov8), 64'h1);
    end
    iv8 = 1'b0;
    step();
    check("stream_end_v", 64'(ov8), 64'h0);
    check("stream_pin_last", 64'(outq8), 64'hC3);

`ifdef NAND_GATE_REDUCE_EN
    a4 = 4'hF; b4 = 4'hF; #1;
    check("red_all_ones", 64'(red4), 64'h0);
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    check("red_q_capture", 64'(redq4), 64'h0);
    a4 = 4'hE; b4 = 4'hF; #1;
    check("red_one_zero", 64'(red4), 64'h1);
    step();
    check("red_q_hold", 64'(redq4), 64'h0);
`else
    a4 = 4'hF; b4 = 4'hF; #1;
    check("w4_comb_ff", 64'(out4), 64'h0);
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    check("w4_capture_q", 64'(outq4), 64'h0);
`endif

    // Randomized traffic with occasional mid-cycle resets.
    for (int n = 0; n < 400; n++) begin
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      iv8 = 1'($urandom_range(0, 2) != 0);
      a4  = 4'($urandom);
      b4  = 4'($urandom);
      iv4 = 1'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      step();
    end
    iv8 = 1'b0;
    iv4 = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_gate.md
Name: nand_gate

Overview:
- Parameterised bitwise 2-input NAND: out = ~(a & b), evaluated per bit.
- Combinational result is available immediately on `out`.
- A registered copy with a valid qualifier (`out_q` / `out_valid`) is available for pipelined consumers.
- Leaf logic block; the WIDTH=1 instance is the basic gate used by higher-level gate-library blocks.

Parameters:
- WIDTH, 1, bit width of operands and results (legal range 1..64).
- RESET_OUT, 1'b1, per-bit reset value of `out_q`. Default all-ones, which equals the NAND of all-zero inputs.

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous reset, active-low.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  qualifies a/b for capture into the registered path.
- out  output  WIDTH  combinational ~(a & b).
- out_q  output  WIDTH  registered ~(a & b), captured when in_valid=1.
- out_valid  output  1  high for exactly the cycle(s) after a capture.

Behaviour:
- Reset and clock: the design has one clock; reset is asynchronous and active-low.
- `out`:
  - purely combinational, zero latency;
  - must not depend on clk, rst_n or in_valid;
  - responds to a/b changes within the same delta/time step, including while rst_n=0.
- Truth table per bit: 00->1, 01->1, 10->1, 11->0.
- Reset (rst_n=0, asynchronous): out_q = {WIDTH{RESET_OUT}}, out_valid = 0, immediately and independent of clk.
- Capture: on rising clk with rst_n=1 and in_valid=1, out_q <= ~(a & b) and out_valid <= 1. Latency is 1 cycle.
- Hold: on rising clk with in_valid=0, out_q holds its value and out_valid <= 0.
- Back-to-back in_valid: one result per cycle, no bubbles, no backpressure.
- Reset deasserted mid-stream: the first capture occurs on the first rising edge after release on which in_valid=1.
- X/Z on a/b propagates per standard Verilog & and ~ semantics. No masking.
- Width rules: all vectors are exactly WIDTH bits; no extension or truncation.

Optional Feature:
- Macro: NAND_GATE_REDUCE_EN.
- When defined:
  - extra output `red` (1 bit, combinational) = ~&(a & b), i.e. 0 only when every bit of a and b is 1;
  - extra output `red_q` (1 bit), registered alongside out_q under the same capture/hold rules;
  - red_q resets to 1.
- When undefined: `red` and `red_q` ports and their logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package `nand_gate_pkg`:
  - constant MAX_WIDTH = 64;
  - function nand_vec(a, b) returning ~(a & b), used by both RTL and bench model;
  - typedef for the default 1-bit gate result.
- Natural sub-module: `nand_bit_cell`, a single-bit NAND cell instantiated WIDTH times via generate, producing `out`.
- The register stage lives in the top module.

Test Plan:
- WIDTH=1 exhaustive sweep, inputs stepping every 50 time units (b toggles every 50, a every 100; sequence (0,0),(0,1),(1,0),(1,1)) -> out = 1,1,1,0 at each step, with no clock required.
- WIDTH=8 combinational check:
  - a=8'hF0, b=8'hCC -> out=8'h3F;
  - a=8'hFF, b=8'hFF -> out=8'h00;
  - a=8'h00, b=8'hFF -> out=8'hFF.
- Registered path, WIDTH=8:
  - in_valid=1 for one cycle with a=8'hAA, b=8'h0F -> next cycle out_q=8'hF5, out_valid=1;
  - following cycle out_valid=0 and out_q holds 8'hF5.
- Async reset mid-operation:
  - assert rst_n=0 between clock edges after a capture -> out_q=8'hFF and out_valid=0 immediately;
  - `out` still tracks a/b during reset.
- Streaming: in_valid held high for 4 cycles with 4 distinct operand pairs -> out_q matches nand_vec of each pair, 1 cycle delayed, and out_valid stays 1 for all 4 result cycles.
- NAND_GATE_REDUCE_EN defined, WIDTH=4:
  - a=b=4'hF -> red=0, and red_q=0 one cycle after capture;
  - a=4'hE, b=4'hF -> red=1.
